// File: rtl/uart_pkg.sv
// Shared UART types and bit-timing helper.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Clocks per serial bit; integer division truncates toward zero.
  function automatic int unsigned clks_per_bit(input int unsigned clock_hz,
                                               input int unsigned baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Host-side and line-side signals of the UART core.
// Latency: none (wiring only).
// Backpressure: none; we/re are single-cycle strobes, ready flags a held byte.
interface uart_if;
  logic       we;
  logic       re;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ready;
  logic       tx;
  logic       rx;

  modport master (output we, re, wdata, rx, input rdata, ready, tx);
  modport slave  (input we, re, wdata, rx, output rdata, ready, tx);
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, centre-sampling FSM, shift and hold register.
// Latency: ready rises about 2 clocks after the stop-bit centre.
// Backpressure: none; a new byte overwrites the held one, and set beats re.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       re,
  output logic [7:0] rx_reg,
  output logic       ready
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s;
  uart_state_e   state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          half_hit, bit_hit;
  logic          cnt_clr, shift_en, byte_done;

  assign rx_s     = sync[1];
  assign half_hit = (cnt == HALF_END);
  assign bit_hit  = (cnt == BIT_END);

  // Bring the asynchronous line into the clk domain; idles high.
  always_ff @(posedge clk) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state: start edge, half-bit glitch check, 8 data bits, stop bit.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (!rx_s) state_nx = ST_START;
      ST_START: if (half_hit) state_nx = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_hit && (bit_idx == 3'd7)) state_nx = ST_STOP;
      ST_STOP:  if (bit_hit) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    cnt_clr   = (state == ST_IDLE) || (state == ST_START && half_hit) || bit_hit;
    shift_en  = (state == ST_DATA) && bit_hit;
    byte_done = (state == ST_STOP) && bit_hit && rx_s;
  end

  // Bit timer and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (state == ST_IDLE) bit_idx <= '0;
      else if (shift_en)    bit_idx <= bit_idx + 1'b1;
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
    end
  end

  // Hold register: a good stop bit loads and flags, re clears, load wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_reg <= '0;
      ready  <= 1'b0;
    end else if (byte_done) begin
      rx_reg <= shreg;
      ready  <= 1'b1;
    end else if (re) begin
      ready  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART: inline transmitter plus uart_rx receiver, fully independent.
// Latency: tx start bit begins the clock after we; frame is 10 bit times.
// Backpressure: we while a frame is in flight is dropped; no RX overrun flag.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ = 50_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input logic  clk,
  input logic  reset,
  uart_if.slave bus
);
  localparam int unsigned CPB = clks_per_bit(CLOCK_HZ, BAUD);
  localparam int unsigned CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);

  uart_state_e   tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shreg;
  logic          tx_bit_hit, tx_cnt_clr, tx_shift, tx_load;
  logic [7:0]    rx_reg;
  logic          rx_ready;

  assign tx_bit_hit = (tx_cnt == BIT_END);

  // TX state register.
  always_ff @(posedge clk) begin
    if (!reset) tx_state <= ST_IDLE;
    else        tx_state <= tx_state_nx;
  end

  // TX next state: each phase lasts whole bit times.
  always_comb begin
    tx_state_nx = tx_state;
    unique case (tx_state)
      ST_IDLE:  if (bus.we) tx_state_nx = ST_START;
      ST_START: if (tx_bit_hit) tx_state_nx = ST_DATA;
      ST_DATA:  if (tx_bit_hit && (tx_idx == 3'd7)) tx_state_nx = ST_STOP;
      ST_STOP:  if (tx_bit_hit) tx_state_nx = ST_IDLE;
      default:  tx_state_nx = ST_IDLE;
    endcase
  end

  // TX outputs: line level and datapath controls.
  always_comb begin
    tx_cnt_clr = (tx_state == ST_IDLE) || tx_bit_hit;
    tx_shift   = (tx_state == ST_DATA) && tx_bit_hit;
    tx_load    = (tx_state == ST_IDLE) && bus.we;
    unique case (tx_state)
      ST_START: bus.tx = 1'b0;
      ST_DATA:  bus.tx = tx_shreg[0];
      default:  bus.tx = 1'b1;
    endcase
  end

  // TX bit timer and shift register; wdata only captured when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
    end else begin
      tx_cnt <= tx_cnt_clr ? '0 : tx_cnt + 1'b1;
      if (tx_load) begin
        tx_shreg <= bus.wdata;
        tx_idx   <= '0;
      end else if (tx_shift) begin
        tx_shreg <= {1'b0, tx_shreg[7:1]};
        tx_idx   <= tx_idx + 1'b1;
      end
    end
  end

  uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk    (clk),
    .reset  (reset),
    .rx     (bus.rx),
    .re     (bus.re),
    .rx_reg (rx_reg),
    .ready  (rx_ready)
  );

  assign bus.ready = rx_ready;
  assign bus.rdata = rx_ready ? rx_reg : 8'h00;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at 50 MHz / 115200 baud (434 clocks per bit).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_core;
  localparam int CPB   = 434;
  localparam int FRAME = 10 * CPB;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   fail_cnt;
  int   total;
  logic       seen_rdy;
  logic [7:0] seen_dat;

  uart_if bus ();

  uart_core #(.CLOCK_HZ(50_000_000), .BAUD(115_200)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a frame and check every cycle of it; optionally pulse we mid-frame.
  task automatic tx_frame(input logic [7:0] d, input int drop_at, input logic [7:0] drop_d);
    logic [9:0] frame;
    int errs [10];
    frame = {1'b1, d, 1'b0};
    for (int b = 0; b < 10; b++) errs[b] = 0;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (bus.tx !== frame[i / CPB]) errs[i / CPB]++;
      if (i == drop_at) begin
        bus.we    = 1'b1;
        bus.wdata = drop_d;
      end else if (i == drop_at + 1) begin
        bus.we    = 1'b0;
      end
      tick();
    end
    for (int b = 0; b < 10; b++) check($sformatf("tx_%02h_bit%0d_errs", d, b), errs[b], 0);
    check($sformatf("tx_%02h_idle_after", d), {31'd0, bus.tx}, 1);
  endtask

  // Drive one rx frame; the stop bit may be shortened. Records any ready seen.
  task automatic rx_send(input logic [7:0] d, input logic stop, input int stop_len);
    logic [9:0] frame;
    int len;
    frame = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      len = (b == 9) ? stop_len : CPB;
      for (int j = 0; j < len; j++) begin
        bus.rx = frame[b];
        if (bus.ready === 1'b1) begin
          seen_rdy = 1'b1;
          seen_dat = bus.rdata;
        end
        tick();
      end
    end
    bus.rx = 1'b1;
  endtask

  initial begin
    int lows;
    pass_cnt = 0;
    fail_cnt = 0;
    total    = 0;
    seen_rdy = 1'b0;
    seen_dat = 8'h00;
    reset     = 1'b0;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    bus.wdata = 8'h00;
    bus.rx    = 1'b1;

    // Reset held for two edges.
    tick();
    tick();
    check("rst_tx",    {31'd0, bus.tx},    1);
    check("rst_ready", {31'd0, bus.ready}, 0);
    check("rst_rdata", {24'd0, bus.rdata}, 8'h00);
    reset = 1'b1;
    tick();

    // 0x55 frame with a dropped 0xAA write 1000 cycles in.
    tx_frame(8'h55, 1000, 8'hAA);
    lows = 0;
    for (int i = 0; i < FRAME + 60; i++) begin
      if (bus.tx !== 1'b1) lows++;
      tick();
    end
    check("tx_no_second_frame", lows, 0);

    // Receive 0xA5, then acknowledge.
    rx_send(8'hA5, 1'b1, CPB);
    check("rx_a5_ready", {31'd0, bus.ready}, 1);
    check("rx_a5_rdata", {24'd0, bus.rdata}, 8'hA5);
    bus.re = 1'b1;
    check("rx_a5_rdata_during_re", {24'd0, bus.rdata}, 8'hA5);
    tick();
    bus.re = 1'b0;
    check("rx_ack_ready", {31'd0, bus.ready}, 0);
    check("rx_ack_rdata", {24'd0, bus.rdata}, 8'h00);

    // 100-cycle low glitch is rejected.
    bus.rx = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    bus.rx = 1'b1;
    for (int i = 0; i < 1000; i++) tick();
    check("rx_glitch_ready", {31'd0, bus.ready}, 0);

    // 0x3C with a low stop bit is discarded.
    seen_rdy = 1'b0;
    rx_send(8'h3C, 1'b0, 300);
    for (int i = 0; i < 1000; i++) begin
      if (bus.ready === 1'b1) seen_rdy = 1'b1;
      tick();
    end
    check("rx_framing_err_ready", {31'd0, seen_rdy}, 0);

    // Overrun: second byte replaces the first, ready stays set.
    rx_send(8'h12, 1'b1, CPB);
    rx_send(8'h34, 1'b1, CPB);
    check("rx_overrun_ready", {31'd0, bus.ready}, 1);
    check("rx_overrun_rdata", {24'd0, bus.rdata}, 8'h34);
    bus.re = 1'b1;
    tick();

    // re held through completion: the new byte must still appear.
    seen_rdy = 1'b0;
    seen_dat = 8'h00;
    rx_send(8'h7E, 1'b1, CPB);
    bus.re = 1'b0;
    check("rx_setwins_seen", {31'd0, seen_rdy}, 1);
    check("rx_setwins_data", {24'd0, seen_dat}, 8'h7E);
    check("rx_setwins_cleared", {31'd0, bus.ready}, 0);

    // Reset during the start bit of 0xFF, then a clean 0x01 frame.
    bus.wdata = 8'hFF;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("tx_ff_start_low", {31'd0, bus.tx}, 0);
    reset = 1'b0;
    tick();
    check("tx_reset_abort", {31'd0, bus.tx}, 1);
    reset = 1'b1;
    tick();
    tx_frame(8'h01, -10, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLOCK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, serial bit rate; CLKS_PER_BIT = CLOCK_HZ/BAUD (integer division, 434 at defaults).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 we  input  1  one-cycle write strobe; starts transmission of wdata.
REQ-006 re  input  1  one-cycle read strobe; acknowledges the received byte.
REQ-007 wdata  input  8  byte to transmit, sampled in the cycle where we=1.
REQ-008 rdata  output  8  received byte when ready=1, else 8'h00.
REQ-009 ready  output  1  received byte available.
REQ-010 tx  output  1  serial line out, 8N1, idle high.
REQ-011 rx  input  1  serial line in, asynchronous, 8N1.

Function
REQ-012 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each CLKS_PER_BIT clocks.
REQ-013 TX states SHALL be IDLE, START, DATA, STOP; we=1 in IDLE latches wdata and drives tx=0 from the next clock edge.
REQ-014 tx SHALL hold each bit exactly CLKS_PER_BIT cycles; full frame is 10*CLKS_PER_BIT cycles, then the transmitter returns to IDLE with tx=1.
REQ-015 we asserted while TX is not IDLE SHALL be ignored (byte dropped, frame in progress unaffected).
REQ-016 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-017 RX states SHALL be IDLE, START, DATA, STOP; IDLE leaves on synchronized rx=0.
REQ-018 In START, rx SHALL be re-sampled after CLKS_PER_BIT/2 cycles; if high, return to IDLE (glitch rejected).
REQ-019 Data bits SHALL be sampled every CLKS_PER_BIT cycles after the start-bit centre, shifted in LSB first.
REQ-020 Stop bit sampled 1: byte SHALL be latched into the receive register and ready set to 1; stop bit sampled 0: byte discarded, ready unchanged (framing error).
REQ-021 re=1 SHALL clear ready at the next edge; rdata stays valid during the re cycle.
REQ-022 A new byte completing while ready=1 SHALL overwrite the receive register; ready stays 1 (overrun, no flag).
REQ-023 re and byte completion in the same cycle: set SHALL win; ready=1 with the new byte.
REQ-024 rdata SHALL be combinational: ready ? receive register : 8'h00.
REQ-025 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-026 On reset=0 at a clock edge: TX and RX to IDLE, tx=1, ready=0, receive register=0, counters=0.
REQ-027 Reset mid-frame SHALL abort both directions; tx SHALL be 1 after that edge; partial RX byte discarded.

Structure
REQ-028 Package uart_pkg SHALL hold the TX/RX state enum and the CLKS_PER_BIT computation function.
REQ-029 Receiver SHALL be one sub-module uart_rx (synchronizer, FSM, shift register); transmitter inline in uart_core.

Verification (CLOCK_HZ=50_000_000, BAUD=115_200, 434 clk/bit)
REQ-030 Reset asserted 2 cycles -> tx=1, ready=0, rdata=8'h00.
REQ-031 we=1, wdata=8'h55 -> tx=0 for 434 cycles, then 1,0,1,0,1,0,1,0 each 434 cycles, stop=1; tx idle after 4340 cycles.
REQ-032 we with 8'hAA 1000 cycles into the 8'h55 frame -> 8'h55 frame unchanged; no second frame follows.
REQ-033 Drive rx frame 8'hA5 -> ready=1, rdata=8'hA5 after stop-bit centre; re pulse -> ready=0, rdata=8'h00 next cycle.
REQ-034 rx low pulse of 100 cycles -> ready stays 0; frame 8'h3C with stop bit 0 -> ready stays 0.
REQ-035 Reset asserted mid-TX of 8'hFF start bit -> tx=1 next cycle; a later we with 8'h01 sends a clean frame.
